biss_frame_check: RTL

Downstream consumer of the BiSS-C acquisition stage and its CRC6 calculator. Takes each completed frame (26-bit position, active-low nError/nWarning bits, received CRC, locally computed CRC), decides whether it is valid, and publishes only validated positions with a wrap-aware signed delta. Tracks link health through a fault state machine, a saturating CRC-error counter and a frame-arrival watchdog. Its outputs feed the control loop and the status registers.

---
 rtl/biss_pkg.sv | 19 +
 rtl/biss_watchdog.sv | 33 +++
 rtl/biss_frame_check.sv | 136 +++++++++++++
 3 files changed

// File: rtl/biss_pkg.sv
// Shared definitions for the BiSS-C receive path: status encodings,
// error-bit positions and the default frame field widths.
package biss_pkg;

    localparam int DEF_DATA_W = 26;
    localparam int DEF_CRC_W  = 6;

    // Bit positions inside the 2-bit error field (both active-low).
    localparam int ERR_N_ERROR = 1;
    localparam int ERR_N_WARN  = 0;

    typedef enum logic [1:0] {
        ST_INIT     = 2'b00,
        ST_OK       = 2'b01,
        ST_DEGRADED = 2'b10,
        ST_FAULT    = 2'b11
    } status_e;

endpackage

// File: rtl/biss_watchdog.sv
// Frame-arrival watchdog: counts cycles since the last kick and pulses
// expire when TIMEOUT_CYC cycles have passed without one.
module biss_watchdog #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    // A kick in the terminal cycle suppresses the pulse, so a frame and a
    // timeout are never reported together.
    assign expire = ~kick & (cnt == LAST);

    // Cycle counter: reload on kick or on expiry, otherwise advance.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples values from before the edge.
        if (rst) begin
            cnt <= '0;
        end else if (kick || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/biss_frame_check.sv
// Validates completed BiSS-C frames, publishes good positions with a
// wrap-aware signed delta, and tracks link health (state machine,
// saturating CRC error counter, frame watchdog).
module biss_frame_check
    import biss_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CRC_W       = DEF_CRC_W,
    parameter int CRC_INV     = 1,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FAULT_N     = 3,
    parameter int RECOVER_N   = 4,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frm_vld,
    input  logic [DATA_W-1:0]        frm_data,
    input  logic [1:0]               frm_err,
    input  logic [CRC_W-1:0]         frm_crc_rx,
    input  logic [CRC_W-1:0]         frm_crc_calc,
    input  logic                     clr_cnt,
    output logic [DATA_W-1:0]        pos_out,
    output logic                     pos_vld,
    output logic signed [DATA_W-1:0] delta_out,
    output logic                     warn,
    output logic [1:0]               status,
    output logic [CNT_W-1:0]         crc_err_cnt,
    output logic                     timeout
);

    localparam int RUN_MAX = (FAULT_N > RECOVER_N) ? FAULT_N : RECOVER_N;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_SAT     = RUN_W'(RUN_MAX);
    localparam logic [RUN_W-1:0] FAULT_LIM   = RUN_W'(FAULT_N);
    localparam logic [RUN_W-1:0] RECOVER_LIM = RUN_W'(RECOVER_N);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [CRC_W-1:0] crc_exp;
    logic             crc_ok;
    logic             good;
    logic             bad;
    logic             expire;
    status_e          state;
    logic             have_ref;
    logic [RUN_W-1:0] bad_run;
    logic [RUN_W-1:0] good_run;
    logic [RUN_W-1:0] bad_run_inc;
    logic [RUN_W-1:0] good_run_inc;

    // The encoder sends the inverted CRC, so compare against ~calc when enabled.
    assign crc_exp = (CRC_INV != 0) ? ~frm_crc_calc : frm_crc_calc;
    assign crc_ok  = (frm_crc_rx == crc_exp);
    assign good    = frm_vld & crc_ok & frm_err[ERR_N_ERROR];
    assign bad     = (frm_vld & ~good) | expire;

    assign bad_run_inc  = (bad_run  == RUN_SAT) ? bad_run  : bad_run  + RUN_W'(1);
    assign good_run_inc = (good_run == RUN_SAT) ? good_run : good_run + RUN_W'(1);

    assign status = state;

    biss_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .kick  (frm_vld),
        .expire(expire)
    );

    // Position path: publish only good frames; delta is zero until a reference exists.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_out   <= '0;
            delta_out <= '0;
            warn      <= 1'b0;
            pos_vld   <= 1'b0;
        end else begin
            pos_vld <= good;
            if (good) begin
                pos_out   <= frm_data;
                delta_out <= have_ref ? frm_data - pos_out : '0;
                warn      <= ~frm_err[ERR_N_WARN];
            end
        end
    end

    // Link health state machine with consecutive good/bad run counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            bad_run  <= '0;
            good_run <= '0;
            have_ref <= 1'b0;
        end else if (good) begin
            bad_run  <= '0;
            good_run <= good_run_inc;
            have_ref <= 1'b1;
            if (state != ST_FAULT || good_run_inc >= RECOVER_LIM) begin
                state <= ST_OK;
            end
        end else if (bad) begin
            good_run <= '0;
            bad_run  <= bad_run_inc;
            case (state)
                ST_OK: state <= ST_DEGRADED;
                ST_DEGRADED: begin
                    if (bad_run_inc >= FAULT_LIM) begin
                        state    <= ST_FAULT;
                        have_ref <= 1'b0;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // Saturating CRC mismatch counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            crc_err_cnt <= '0;
        end else if (frm_vld && !crc_ok && crc_err_cnt != CNT_MAX) begin
            crc_err_cnt <= crc_err_cnt + CNT_W'(1);
        end
    end

    // Registered copy of the watchdog expiry pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= expire;
        end
    end

endmodule
